guess_game_sequencer: RTL and testbench



---
 rtl/guess_game_pkg.sv | 29 ++
 rtl/guess_game_sequencer_button.sv | 69 ++++++
 rtl/guess_game_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_guess_game_sequencer.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/guess_game_pkg.sv
// -----------------------------------------------------------------------------
// guess_game_pkg
//   Shared definitions for the number-guessing game sequencer.
//   - state_e   : sequencer FSM states
//   - LFSR_SEED : LFSR value after reset (never zero)
//   - LFSR_TAPS : feedback mask for the 8-bit Fibonacci LFSR (taps 8,6,5,4)
//   - lfsr_next : one shift-left step of the LFSR
// -----------------------------------------------------------------------------
package guess_game_pkg;

    typedef enum logic [2:0] {
        S_SEED  = 3'd0,
        S_LOAD  = 3'd1,
        S_WAIT  = 3'd2,
        S_CHECK = 3'd3,
        S_WIN   = 3'd4,
        S_LOSE  = 3'd5
    } state_e;

    localparam logic [7:0] LFSR_SEED = 8'h01;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // Shift left, feedback = XOR of bits 7,5,4,3 (polynomial taps 8,6,5,4).
    // Starting from a non-zero seed this sequence never reaches zero.
    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/guess_game_sequencer_button.sv
// -----------------------------------------------------------------------------
// button_conditioner
//   Turns a raw, bouncing, asynchronous button level into a single-cycle
//   press pulse.
//   Ports:
//     clk_i    : system clock
//     rst_ni   : asynchronous active-low reset
//     enter_i  : raw button level, asynchronous to clk_i
//     press_o  : one-cycle pulse on a debounced 0->1 transition
//   Behaviour:
//     A 2-flop synchronizer feeds a debounce counter. The debounced level
//     only changes after DB_CYCLES consecutive cycles of a new synchronized
//     value. press_o is asserted in the cycle whose clock edge commits the
//     debounced rise, so the raw-edge to press latency is 2 + DB_CYCLES.
// -----------------------------------------------------------------------------
module button_conditioner #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic enter_i,
    output logic press_o
);

    localparam int              CW       = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          press;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= enter_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    // cnt_q counts how many consecutive synchronized samples already
    // disagreed with level_q. The DB_CYCLES-th disagreeing sample flips the
    // level; any agreeing sample restarts the count.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        press   = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                press   = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    assign press_o = press;

endmodule

// File: rtl/guess_game_sequencer.sv
// -----------------------------------------------------------------------------
// guess_game_sequencer
//   Top-level sequencer of the number-guessing game. Conditions the enter
//   button, picks a pseudo-random target from a free-running LFSR, hands it
//   to the guess datapath, samples the datapath compare flags once per
//   accepted guess, counts attempts and ends the game in WIN or LOSE.
//   Ports:
//     clk            : system clock
//     reset          : asynchronous active-low reset
//     i_enter        : raw enter button level (asynchronous)
//     i_new_game     : synchronous restart request (level)
//     i_over/under/equal : datapath compare flags (guess vs target)
//     o_load_target  : one-cycle strobe, datapath captures o_target
//     o_target       : captured target value
//     o_over/under/equal : registered LED copies of the compare flags
//     o_attempts     : guesses consumed in this game (saturating)
//     o_win / o_lose : high while in S_WIN / S_LOSE
//     o_dbg_state    : current FSM state
//     o_dbg_lfsr     : current LFSR value
//
//   Load strobe contract: o_load_target is a single-cycle strobe with no
//   back-pressure; o_target is already valid in the strobe cycle and stays
//   stable until the next strobe, so the datapath may capture it in that
//   cycle and nothing has to be acknowledged.
// -----------------------------------------------------------------------------
module guess_game_sequencer
    import guess_game_pkg::*;
#(
    parameter int MAX_ATTEMPTS = 8,
    parameter int DB_CYCLES    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_enter,
    input  logic       i_new_game,
    input  logic       i_over,
    input  logic       i_under,
    input  logic       i_equal,
    output logic       o_load_target,
    output logic [7:0] o_target,
    output logic       o_over,
    output logic       o_under,
    output logic       o_equal,
    output logic [3:0] o_attempts,
    output logic       o_win,
    output logic       o_lose,
    output state_e     o_dbg_state,
    output logic [7:0] o_dbg_lfsr
);

    localparam logic [3:0] MAX_A = 4'(MAX_ATTEMPTS);

    logic       press;
    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;
    state_e     state_q;
    logic [7:0] target_q;
    logic       load_q;
    logic       over_q;
    logic       under_q;
    logic       equal_q;
    logic [3:0] attempts_q;
    logic [3:0] attempts_d;
    logic       win_q;
    logic       lose_q;

    // -------------------------------------------------------------------------
    // Enter button conditioning
    // -------------------------------------------------------------------------
    button_conditioner #(
        .DB_CYCLES (DB_CYCLES)
    ) u_button (
        .clk_i   (clk),
        .rst_ni  (reset),
        .enter_i (i_enter),
        .press_o (press)
    );

    // -------------------------------------------------------------------------
    // Free-running LFSR: steps every cycle in every state, so the target
    // depends on how long the player took to press enter.
    // -------------------------------------------------------------------------
    assign lfsr_d = lfsr_next(lfsr_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // Attempt counter never wraps; in practice the FSM leaves for S_LOSE
    // when the count reaches MAX_ATTEMPTS, this only guards the boundary.
    assign attempts_d = (attempts_q == MAX_A) ? attempts_q : attempts_q + 4'd1;

    // -------------------------------------------------------------------------
    // Game FSM with registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_SEED;
            target_q   <= 8'h00;
            load_q     <= 1'b0;
            over_q     <= 1'b0;
            under_q    <= 1'b0;
            equal_q    <= 1'b0;
            attempts_q <= 4'd0;
            win_q      <= 1'b0;
            lose_q     <= 1'b0;
        end else if (i_new_game) begin
            // Restart wins over a simultaneous press or CHECK outcome.
            // target_q is kept: the datapath still holds it and the next
            // game always reloads a fresh one.
            state_q    <= S_SEED;
            load_q     <= 1'b0;
            over_q     <= 1'b0;
            under_q    <= 1'b0;
            equal_q    <= 1'b0;
            attempts_q <= 4'd0;
            win_q      <= 1'b0;
            lose_q     <= 1'b0;
        end else begin
            load_q <= 1'b0;
            case (state_q)
                S_SEED: begin
                    if (press) begin
                        target_q <= lfsr_q;
                        load_q   <= 1'b1;
                        state_q  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    attempts_q <= 4'd0;
                    over_q     <= 1'b0;
                    under_q    <= 1'b0;
                    equal_q    <= 1'b0;
                    state_q    <= S_WAIT;
                end
                S_WAIT: begin
                    if (press) begin
                        state_q <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    // The datapath compared against a target loaded at
                    // least two cycles ago, so its flags are settled here.
                    over_q     <= i_over;
                    under_q    <= i_under;
                    equal_q    <= i_equal;
                    attempts_q <= attempts_d;
                    if (i_equal) begin
                        win_q   <= 1'b1;
                        state_q <= S_WIN;
                    end else if (attempts_d == MAX_A) begin
                        lose_q  <= 1'b1;
                        state_q <= S_LOSE;
                    end else begin
                        state_q <= S_WAIT;
                    end
                end
                S_WIN, S_LOSE: begin
                    // Terminal: only i_new_game or reset leaves.
                end
                default: begin
                    state_q <= S_SEED;
                end
            endcase
        end
    end

    assign o_load_target = load_q;
    assign o_target      = target_q;
    assign o_over        = over_q;
    assign o_under       = under_q;
    assign o_equal       = equal_q;
    assign o_attempts    = attempts_q;
    assign o_win         = win_q;
    assign o_lose        = lose_q;
    assign o_dbg_state   = state_q;
    assign o_dbg_lfsr    = lfsr_q;

endmodule

// File: tb/tb_guess_game_sequencer.sv
module tb_guess_game_sequencer;
  import guess_game_pkg::*;

  localparam int DB  = 4;
  localparam int MAX = 8;

  // ---------------------------------------------------------------------------
  // DUT signals
  // ---------------------------------------------------------------------------
  logic       clk;
  logic       reset;
  logic       i_enter;
  logic       i_new_game;
  logic       i_over;
  logic       i_under;
  logic       i_equal;
  logic       o_load_target;
  logic [7:0] o_target;
  logic       o_over;
  logic       o_under;
  logic       o_equal;
  logic [3:0] o_attempts;
  logic       o_win;
  logic       o_lose;
  state_e     dut_state;
  logic [7:0] dut_lfsr;

  int checks;
  int failures;

  // scoreboard: targets the model expects to see on o_load_target strobes
  logic [7:0] exp_q[$];

  // ---------------------------------------------------------------------------
  // Reference model state
  // ---------------------------------------------------------------------------
  logic       raw_hist[$];
  logic       syn_hist[$];
  logic       m_db;
  logic [7:0] m_lfsr;
  logic [7:0] m_target;
  logic       m_load;
  logic       m_over;
  logic       m_under;
  logic       m_equal;
  int         m_att;
  logic       m_win;
  logic       m_lose;
  state_e     m_state;

  guess_game_sequencer #(
    .MAX_ATTEMPTS (MAX),
    .DB_CYCLES    (DB)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .i_enter       (i_enter),
    .i_new_game    (i_new_game),
    .i_over        (i_over),
    .i_under       (i_under),
    .i_equal       (i_equal),
    .o_load_target (o_load_target),
    .o_target      (o_target),
    .o_over        (o_over),
    .o_under       (o_under),
    .o_equal       (o_equal),
    .o_attempts    (o_attempts),
    .o_win         (o_win),
    .o_lose        (o_lose),
    .o_dbg_state   (dut_state),
    .o_dbg_lfsr    (dut_lfsr)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] lfsr_step(input logic [7:0] x);
    int v;
    int fb;
    v  = int'(x);
    fb = ((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1;
    return 8'(((v << 1) | fb) & 255);
  endfunction

  task automatic model_reset();
    raw_hist.delete();
    syn_hist.delete();
    raw_hist.push_back(1'b0);
    raw_hist.push_back(1'b0);
    exp_q.delete();
    m_db     = 1'b0;
    m_lfsr   = 8'h01;
    m_target = 8'h00;
    m_load   = 1'b0;
    m_over   = 1'b0;
    m_under  = 1'b0;
    m_equal  = 1'b0;
    m_att    = 0;
    m_win    = 1'b0;
    m_lose   = 1'b0;
    m_state  = S_SEED;
  endtask

  // One clock edge worth of game rules, using the inputs present before it.
  task automatic model_edge();
    logic s;
    logic press;
    logic all_diff;
    logic [7:0] lf;
    // synchronized sample seen at this edge is the raw level two edges back
    s = raw_hist[raw_hist.size() - 2];
    syn_hist.push_back(s);
    if (syn_hist.size() > 16) syn_hist.delete(0);
    press = 1'b0;
    if (syn_hist.size() >= DB) begin
      all_diff = 1'b1;
      for (int i = 0; i < DB; i++)
        if (syn_hist[syn_hist.size() - 1 - i] == m_db) all_diff = 1'b0;
      if (all_diff) begin
        m_db  = ~m_db;
        press = m_db;
      end
    end
    raw_hist.push_back(i_enter);
    if (raw_hist.size() > 16) raw_hist.delete(0);

    lf     = m_lfsr;
    m_lfsr = lfsr_step(m_lfsr);

    if (i_new_game) begin
      m_state = S_SEED;
      m_load  = 1'b0;
      m_over  = 1'b0;
      m_under = 1'b0;
      m_equal = 1'b0;
      m_att   = 0;
      m_win   = 1'b0;
      m_lose  = 1'b0;
    end else begin
      m_load = 1'b0;
      case (m_state)
        S_SEED: if (press) begin
          m_target = lf;
          m_load   = 1'b1;
          m_state  = S_LOAD;
          exp_q.push_back(lf);
        end
        S_LOAD: begin
          m_att   = 0;
          m_over  = 1'b0;
          m_under = 1'b0;
          m_equal = 1'b0;
          m_state = S_WAIT;
        end
        S_WAIT: if (press) m_state = S_CHECK;
        S_CHECK: begin
          m_over  = i_over;
          m_under = i_under;
          m_equal = i_equal;
          if (m_att < MAX) m_att = m_att + 1;
          if (i_equal) begin
            m_win   = 1'b1;
            m_state = S_WIN;
          end else if (m_att == MAX) begin
            m_lose  = 1'b1;
            m_state = S_LOSE;
          end else begin
            m_state = S_WAIT;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic compare_all();
    logic [7:0] t;
    check_eq("load",    32'(o_load_target), 32'(m_load));
    check_eq("target",  32'(o_target),      32'(m_target));
    check_eq("over",    32'(o_over),        32'(m_over));
    check_eq("under",   32'(o_under),       32'(m_under));
    check_eq("equal",   32'(o_equal),       32'(m_equal));
    check_eq("att",     32'(o_attempts),    32'(m_att));
    check_eq("win",     32'(o_win),         32'(m_win));
    check_eq("lose",    32'(o_lose),        32'(m_lose));
    check_eq("state",   32'(dut_state),     32'(m_state));
    check_eq("lfsr",    32'(dut_lfsr),      32'(m_lfsr));
    check_eq("lfsr_nz", 32'(dut_lfsr != 8'h00), 32'(1));
    if (o_load_target) begin
      check_eq("sb_avail", 32'(exp_q.size() > 0), 32'(1));
      if (exp_q.size() > 0) begin
        t = exp_q.pop_front();
        check_eq("sb_target", 32'(o_target), 32'(t));
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    if (!reset) model_reset();
    else        model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_guess(input logic [7:0] g);
    i_over  = (g > m_target);
    i_under = (g < m_target);
    i_equal = (g == m_target);
  endtask

  task automatic start_game();
    i_new_game = 1'b1;
    step();
    i_new_game = 1'b0;
    i_enter = 1'b1;
    steps(8);
    i_enter = 1'b0;
    steps(10);
  endtask

  task automatic guess_plain(input logic [7:0] g, input int hold);
    set_guess(g);
    i_enter = 1'b1;
    steps(hold);
    i_enter = 1'b0;
    steps(10);
  endtask

  task automatic guess_timed(input logic [7:0] g, input string tag);
    set_guess(g);
    i_enter = 1'b1;
    steps(6);
    check_eq({tag, "_chk"}, 32'(dut_state), 32'(S_CHECK));
    step();
    steps(2);
    i_enter = 1'b0;
    steps(10);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [7:0] lfsr_exp [4];
    logic [7:0] t;
    logic [7:0] g;
    int n_load;
    int load_at;
    int tries;
    int hold;

    checks     = 0;
    failures   = 0;
    reset      = 1'b0;
    i_enter    = 1'b0;
    i_new_game = 1'b0;
    i_over     = 1'b0;
    i_under    = 1'b0;
    i_equal    = 1'b0;
    model_reset();

    // reset held for 3 cycles, then released
    steps(3);
    reset = 1'b1;
    #1;
    check_eq("rst_load",  32'(o_load_target), 32'(0));
    check_eq("rst_tgt",   32'(o_target),      32'(0));
    check_eq("rst_flags", 32'({o_over, o_under, o_equal}), 32'(0));
    check_eq("rst_att",   32'(o_attempts),    32'(0));
    check_eq("rst_wl",    32'({o_win, o_lose}), 32'(0));
    check_eq("rst_state", 32'(dut_state),     32'(S_SEED));

    lfsr_exp[0] = 8'h01;
    lfsr_exp[1] = 8'h02;
    lfsr_exp[2] = 8'h04;
    lfsr_exp[3] = 8'h08;
    check_eq("lfsr_seq0", 32'(dut_lfsr), 32'(lfsr_exp[0]));
    for (int i = 1; i < 4; i++) begin
      step();
      check_eq("lfsr_seq", 32'(dut_lfsr), 32'(lfsr_exp[i]));
    end

    // bounce 1-0-1 then hold high 6 cycles
    i_enter = 1'b1;
    step();
    i_enter = 1'b0;
    step();
    i_enter = 1'b1;
    n_load  = 0;
    load_at = -1;
    for (int i = 1; i <= 16; i++) begin
      if (i == 7) i_enter = 1'b0;
      step();
      if (o_load_target) begin
        n_load++;
        load_at = i;
        check_eq("bounce_tgt", 32'(o_target), 32'(m_target));
      end
    end
    check_eq("bounce_cnt", 32'(n_load),  32'(1));
    check_eq("bounce_lat", 32'(load_at), 32'(6));

    // correct on the third guess
    t = m_target;
    g = t + 8'd5;
    guess_timed(g, "g1");
    check_eq("g1_over", 32'(o_over), 32'(g > t));
    check_eq("g1_att",  32'(o_attempts), 32'(1));
    g = t - 8'd3;
    guess_timed(g, "g2");
    check_eq("g2_under", 32'(o_under), 32'(g < t));
    check_eq("g2_att",   32'(o_attempts), 32'(2));
    guess_timed(t, "g3");
    check_eq("g3_equal", 32'(o_equal), 32'(1));
    check_eq("g3_att",   32'(o_attempts), 32'(3));
    check_eq("g3_win",   32'(o_win), 32'(1));

    // out of attempts: every guess over the target
    start_game();
    tries = 0;
    while (m_target == 8'hFF && tries < 5) begin
      start_game();
      tries++;
    end
    t = m_target;
    for (int i = 0; i < MAX; i++) begin
      g = t + 8'd1 + 8'($urandom_range(0, 254 - int'(t)));
      guess_plain(g, 8);
    end
    check_eq("oa_lose", 32'(o_lose), 32'(1));
    check_eq("oa_att",  32'(o_attempts), 32'(MAX));
    check_eq("oa_over", 32'(o_over), 32'(1));
    guess_plain(t + 8'd1, 8);
    check_eq("oa9_att",   32'(o_attempts), 32'(MAX));
    check_eq("oa9_lose",  32'(o_lose), 32'(1));
    check_eq("oa9_state", 32'(dut_state), 32'(S_LOSE));

    // held enter counts one guess
    start_game();
    set_guess(m_target + 8'd1);
    i_enter = 1'b1;
    steps(50);
    i_enter = 1'b0;
    steps(10);
    check_eq("held_att", 32'(o_attempts), 32'(1));

    // restart request in the same cycle as a press in S_WAIT
    i_enter = 1'b1;
    steps(5);
    i_new_game = 1'b1;
    step();
    i_new_game = 1'b0;
    check_eq("ng_state", 32'(dut_state), 32'(S_SEED));
    check_eq("ng_att",   32'(o_attempts), 32'(0));
    i_enter = 1'b0;
    steps(10);

    // asynchronous reset in the middle of S_CHECK
    start_game();
    set_guess(m_target + 8'd1);
    i_enter = 1'b1;
    steps(6);
    check_eq("ar_chk", 32'(dut_state), 32'(S_CHECK));
    #2;
    reset = 1'b0;
    #1;
    check_eq("ar_load",  32'(o_load_target), 32'(0));
    check_eq("ar_tgt",   32'(o_target), 32'(0));
    check_eq("ar_flags", 32'({o_over, o_under, o_equal}), 32'(0));
    check_eq("ar_att",   32'(o_attempts), 32'(0));
    check_eq("ar_wl",    32'({o_win, o_lose}), 32'(0));
    check_eq("ar_state", 32'(dut_state), 32'(S_SEED));
    check_eq("ar_lfsr",  32'(dut_lfsr), 32'(8'h01));
    model_reset();
    i_enter = 1'b0;
    steps(2);
    reset = 1'b1;
    steps(3);

    // randomized games
    for (int gm = 0; gm < 30; gm++) begin
      start_game();
      tries = 0;
      while (m_state != S_WIN && m_state != S_LOSE && tries < 12) begin
        if ($urandom_range(0, 3) == 0) g = m_target;
        else                           g = 8'($urandom_range(0, 255));
        set_guess(g);
        hold = $urandom_range(1, 12);
        i_enter = 1'b1;
        for (int k = 0; k < hold; k++) begin
          i_new_game = ($urandom_range(0, 39) == 0);
          step();
        end
        i_new_game = 1'b0;
        i_enter = 1'b0;
        steps($urandom_range(1, 12));
        tries++;
      end
      i_enter = 1'b0;
      steps(8);
    end

    check_eq("sb_drain", 32'(exp_q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
